// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the 5-stage RV32 pipeline
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_r,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_disable_stall,
    input  logic             ex_redirect,
    input  logic             im_busy,
    input  logic             dm_busy,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_stall,
    output logic             redirect_ok,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_RUN      = 3'b001,
        S_MEM_WAIT = 3'b010,
        S_FLUSH    = 3'b100
    } state_t;

    state_t     state, state_n;
    logic [2:0] flush_cnt, flush_cnt_n;
    logic       pending, pending_n;
    logic       saved_flush, saved_flush_n;

    logic       mem_wait;
    logic       redir;
    logic       in_flush;
    logic       load_use;

    assign mem_wait = im_busy | dm_busy;
    assign redir    = ex_redirect | pending;
    // Leaving MEM_WAIT behaves as whichever state was interrupted.
    assign in_flush = (state == S_FLUSH) || ((state == S_MEM_WAIT) && saved_flush);
    assign load_use = ex_mem_r && !ex_disable_stall && (ex_wr_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_wr_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_wr_addr)));

    always_comb begin
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_stall   = 1'b0;
        ID_EX_flush   = 1'b0;
        EX_MEM_stall  = 1'b0;
        MEM_WB_stall  = 1'b0;
        redirect_ok   = 1'b0;
        state_n       = S_RUN;
        flush_cnt_n   = flush_cnt;
        pending_n     = pending;
        saved_flush_n = saved_flush;

        if (!rst) begin
            flush_cnt_n   = 3'd0;
            pending_n     = 1'b0;
            saved_flush_n = 1'b0;
        end else if (mem_wait) begin
            pc_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_stall  = 1'b1;
            MEM_WB_stall  = 1'b1;
            state_n       = S_MEM_WAIT;
            saved_flush_n = in_flush;
            pending_n     = pending | ex_redirect;
        end else if (redir) begin
            IF_ID_flush   = 1'b1;
            ID_EX_flush   = 1'b1;
            redirect_ok   = 1'b1;
            pending_n     = 1'b0;
            saved_flush_n = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_n     = S_FLUSH;
                flush_cnt_n = 3'(FLUSH_CYCLES - 1);
            end else begin
                flush_cnt_n = 3'd0;
            end
        end else if (in_flush) begin
            IF_ID_flush   = 1'b1;
            saved_flush_n = 1'b0;
            if (flush_cnt <= 3'd1) begin
                flush_cnt_n = 3'd0;
            end else begin
                state_n     = S_FLUSH;
                flush_cnt_n = flush_cnt - 3'd1;
            end
        end else begin
            saved_flush_n = 1'b0;
            if (load_use) begin
                pc_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RUN;
            flush_cnt   <= 3'd0;
            pending     <= 1'b0;
            saved_flush <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_n;
            flush_cnt   <= flush_cnt_n;
            pending     <= pending_n;
            saved_flush <= saved_flush_n;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_wr_addr;
    logic             id_rs1_used, id_rs2_used, ex_mem_r, ex_disable_stall;
    logic             ex_redirect, im_busy, dm_busy;
    logic             pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic             EX_MEM_stall, MEM_WB_stall, redirect_ok;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_pc  = 1'b0;

    // {pc, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_stall, redirect_ok}
    localparam logic [7:0] V_ZERO  = 8'b0000_0000;
    localparam logic [7:0] V_LU    = 8'b1100_1000;
    localparam logic [7:0] V_REDIR = 8'b0010_1001;
    localparam logic [7:0] V_FL    = 8'b0010_0000;
    localparam logic [7:0] V_WAIT  = 8'b1101_0110;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_r(ex_mem_r), .ex_wr_addr(ex_wr_addr),
        .ex_disable_stall(ex_disable_stall), .ex_redirect(ex_redirect),
        .im_busy(im_busy), .dm_busy(dm_busy),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
        .redirect_ok(redirect_ok), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [7:0] exp_v);
        logic [7:0] obs;
        #4;
        obs = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_stall, redirect_ok};
        checks++;
        exp_pc = exp_v[7];
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_cnt(input string tag);
        checks++;
        assert (stall_cnt === exp_cnt) else begin
            failures++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) exp_cnt = '0;
        else if (exp_pc && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        exp_pc = 1'b0;
        #1;
    endtask

    task automatic clear_in();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_wr_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_r = 1'b0;
        ex_disable_stall = 1'b0; ex_redirect = 1'b0; im_busy = 1'b0; dm_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_rs1_addr = rs1; id_rs2_addr = rs2; ex_wr_addr = rd;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1; ex_mem_r = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        @(posedge clk); @(posedge clk); #1;

        // Outputs forced low while in reset even with requests present
        ex_redirect = 1'b1; im_busy = 1'b1;
        check_out("reset_outputs", V_ZERO);
        tick();
        check_cnt("reset_cnt");
        clear_in(); rst = 1'b1;
        check_out("idle", V_ZERO);
        tick();

        // Load-use on rs2
        set_lu(5'd3, 5'd5, 5'd5);
        check_out("lu_rs2", V_LU);
        tick();
        ex_mem_r = 1'b0;
        check_out("lu_bubble", V_ZERO);
        checks++;
        assert (stall_cnt === 4'd1) else begin
            failures++;
            $error("FAIL lu_cnt stall_cnt observed=%0d expected=1", stall_cnt);
        end
        tick();

        // Load-use on rs1, then rs1 unused
        set_lu(5'd7, 5'd2, 5'd7);
        check_out("lu_rs1", V_LU);
        tick();
        check_cnt("lu_rs1_cnt");
        id_rs1_used = 1'b0;
        check_out("lu_rs1_unused", V_ZERO);
        tick();

        // No hazard: rd=x0, exempt, not a load
        set_lu(5'd0, 5'd0, 5'd0);
        check_out("lu_x0", V_ZERO);
        tick();
        set_lu(5'd5, 5'd5, 5'd5); ex_disable_stall = 1'b1;
        check_out("lu_disabled", V_ZERO);
        tick();
        ex_disable_stall = 1'b0; ex_mem_r = 1'b0;
        check_out("lu_not_load", V_ZERO);
        tick();
        clear_in();

        // Redirect pulse
        ex_redirect = 1'b1;
        check_out("redir_c0", V_REDIR);
        tick();
        ex_redirect = 1'b0;
        check_out("redir_c1", V_FL);
        tick();
        check_out("redir_c2", V_ZERO);
        tick();

        // Redirect beats load-use; load-use ignored during FLUSH
        set_lu(5'd9, 5'd9, 5'd9); ex_redirect = 1'b1;
        check_out("redir_over_lu", V_REDIR);
        tick();
        ex_redirect = 1'b0;
        check_out("flush_ignores_lu", V_FL);
        tick();
        clear_in();
        check_out("after_flush_lu", V_ZERO);
        check_cnt("redir_cnt");
        tick();

        // dm_busy for 4 cycles with redirect in the 2nd
        dm_busy = 1'b1;
        check_out("wait_c1", V_WAIT);
        tick();
        ex_redirect = 1'b1;
        check_out("wait_c2", V_WAIT);
        tick();
        ex_redirect = 1'b0;
        check_out("wait_c3", V_WAIT);
        tick();
        check_out("wait_c4", V_WAIT);
        tick();
        dm_busy = 1'b0;
        check_out("wait_pending_redir", V_REDIR);
        check_cnt("wait_cnt");
        tick();
        check_out("wait_flush", V_FL);
        tick();
        check_out("wait_done", V_ZERO);
        tick();

        // Memory wait inside FLUSH resumes the flush
        ex_redirect = 1'b1;
        check_out("fw_redir", V_REDIR);
        tick();
        ex_redirect = 1'b0; im_busy = 1'b1;
        check_out("fw_wait", V_WAIT);
        tick();
        im_busy = 1'b0;
        check_out("fw_resume", V_FL);
        tick();
        check_out("fw_done", V_ZERO);
        tick();

        // New redirect during FLUSH restarts it
        ex_redirect = 1'b1;
        check_out("rr_c0", V_REDIR);
        tick();
        check_out("rr_c1", V_REDIR);
        tick();
        ex_redirect = 1'b0;
        check_out("rr_c2", V_FL);
        tick();
        check_out("rr_c3", V_ZERO);
        tick();

        // Reset in FLUSH with flush_cnt=1
        ex_redirect = 1'b1;
        check_out("rf_redir", V_REDIR);
        tick();
        ex_redirect = 1'b0; rst = 1'b0;
        check_out("rf_in_reset", V_ZERO);
        tick();
        rst = 1'b1;
        check_out("rf_after", V_ZERO);
        check_cnt("rf_cnt");
        tick();

        // Reset in MEM_WAIT discards the pending redirect
        dm_busy = 1'b1; ex_redirect = 1'b1;
        check_out("rw_wait", V_WAIT);
        tick();
        clear_in(); rst = 1'b0;
        check_out("rw_in_reset", V_ZERO);
        tick();
        rst = 1'b1;
        check_out("rw_no_pending", V_ZERO);
        check_cnt("rw_cnt");
        tick();

        // Counter saturation
        im_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check_out("sat_wait", V_WAIT);
            tick();
        end
        checks++;
        assert (stall_cnt === 4'hF) else begin
            failures++;
            $error("FAIL sat_cnt stall_cnt observed=%0d expected=15", stall_cnt);
        end
        im_busy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
